fib_seq_ctrl: RTL and testbench

//  Request/response controller for the Fibonacci previous/present datapath.
//  - A requester submits index n over a valid/ready handshake.
//  - The block sequences the add-and-shift recurrence (F(0)=0, F(1)=1) for exactly n steps.
//  - It returns F(n) (single mode) or every term F(0)..F(n) (stream mode) over a backpressured

---
 rtl/fib_pkg.sv | 13 +
 rtl/fib_step.sv | 38 +++
 rtl/fib_seq_ctrl.sv | 103 ++++++++++
 tb/tb_fib_seq_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fib_pkg.sv
// Shared types and constants for the Fibonacci sequencing controller.
package fib_pkg;

  localparam int unsigned FIB_W            = 32;
  localparam int unsigned FIB_MAX_SAFE_IDX = 47;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/fib_step.sv
// Registered previous/present term pair with load/advance enables and overflow tracking.
module fib_step
  import fib_pkg::*;
#(
  parameter int unsigned WIDTH = FIB_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             advance,
  output logic [WIDTH-1:0] prev,
  output logic [WIDTH-1:0] pres,
  output logic             prev_ovf,
  output logic             pres_ovf
);

  localparam logic [WIDTH-1:0] One = WIDTH'(1);

  logic [WIDTH:0] sum;

  // Top bit of the widened sum is the carry out of the modulo add.
  assign sum = {1'b0, prev} + {1'b0, pres};

  always_ff @(posedge clk) begin
    if (rst || load) begin
      prev     <= '0;
      pres     <= One;
      prev_ovf <= 1'b0;
      pres_ovf <= 1'b0;
    end else if (advance) begin
      prev     <= pres;
      pres     <= sum[WIDTH-1:0];
      prev_ovf <= pres_ovf;
      pres_ovf <= prev_ovf | pres_ovf | sum[WIDTH];
    end
  end

endmodule

// File: rtl/fib_seq_ctrl.sv
// Request/response controller sequencing the Fibonacci recurrence for n steps.
module fib_seq_ctrl
  import fib_pkg::*;
#(
  parameter int unsigned WIDTH = FIB_W,
  parameter int unsigned IDX_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [IDX_W-1:0] req_n,
  input  logic             req_stream,
  input  logic             abort,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_last,
  output logic             rsp_ovf,
  output logic             busy
);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] n_q, cnt_q;
  logic             stream_q;
  logic             load, advance, is_last;
  logic [WIDTH-1:0] prev, pres;
  logic             prev_ovf, pres_ovf;

  fib_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .advance (advance),
    .prev    (prev),
    .pres    (pres),
    .prev_ovf(prev_ovf),
    .pres_ovf(pres_ovf)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      n_q      <= '0;
      cnt_q    <= '0;
      stream_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load) begin
        n_q      <= req_n;
        stream_q <= req_stream;
        cnt_q    <= '0;
      end else if (advance) begin
        cnt_q <= cnt_q + IDX_W'(1);
      end
    end
  end

  assign is_last = (cnt_q == n_q);

  // Abort outranks both stepping and the response handshake.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    advance = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_valid && req_ready) begin
          load    = 1'b1;
          state_d = StRun;
        end
      end
      StRun: begin
        if (abort) begin
          state_d = StIdle;
        end else if (!stream_q) begin
          if (is_last) state_d = StDone;
          else         advance = 1'b1;
        end else if (rsp_ready) begin
          if (is_last) state_d = StIdle;
          else         advance = 1'b1;
        end
      end
      StDone: begin
        if (abort || rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign req_ready = (state_q == StIdle) && !abort;
  assign busy      = (state_q != StIdle);
  assign rsp_valid = (state_q == StDone) || ((state_q == StRun) && stream_q);
  assign rsp_last  = (state_q == StDone) || ((state_q == StRun) && stream_q && is_last);
  assign rsp_data  = rsp_valid ? prev : '0;
  assign rsp_ovf   = rsp_valid & prev_ovf;

  logic unused_pres;
  assign unused_pres = ^pres;

endmodule

// File: tb/tb_fib_seq_ctrl.sv
// Directed bench for fib_seq_ctrl with a beat scoreboard fed from a wide-arithmetic model.
module tb_fib_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_stream, abort;
  logic [5:0]  req_n;
  logic        rsp_valid, rsp_ready, rsp_last, rsp_ovf, busy;
  logic [31:0] rsp_data;

  int tests = 0;
  int fails = 0;

  logic [33:0] sb[$];
  logic        stall_q = 1'b0;
  logic [31:0] stall_data = '0;

  fib_seq_ctrl #(
    .WIDTH(32),
    .IDX_W(6)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_n     (req_n),
    .req_stream(req_stream),
    .abort     (abort),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_last  (rsp_last),
    .rsp_ovf   (rsp_ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Beat = {data mod 2^32, last, true value >= 2^32}.
  function automatic logic [33:0] model(input int n, input bit last);
    logic [63:0] a, b, t;
    a = 64'd0;
    b = 64'd1;
    for (int i = 0; i < n; i++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return {a[31:0], last, (a > 64'hFFFF_FFFF)};
  endfunction

  task automatic push_single(input int n);
    sb.push_back(model(n, 1'b1));
  endtask

  task automatic push_stream(input int n);
    for (int i = 0; i <= n; i++) sb.push_back(model(i, i == n));
  endtask

  // Called just after a posedge; returns just after the accepting posedge.
  task automatic req(input int n, input bit stream);
    int k;
    k = 0;
    req_valid  = 1'b1;
    req_n      = 6'(n);
    req_stream = stream;
    @(negedge clk);
    while (!req_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("req_accept", {63'd0, req_ready}, 64'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!rsp_valid && lat < 200);
    check("valid_seen", {63'd0, rsp_valid}, 64'd1);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (sb.size() != 0 && k < 300) begin
      @(negedge clk);
      k++;
    end
    check("drain", 64'(sb.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst && stall_q)
      check("stall_hold", {31'd0, rsp_valid, rsp_data}, {31'd0, 1'b1, stall_data});
    stall_q    <= !rst && !abort && rsp_valid && !rsp_ready;
    stall_data <= rsp_data;
    if (!rst && rsp_valid && rsp_ready) begin
      check("sb_nonempty", {63'd0, sb.size() != 0}, 64'd1);
      if (sb.size() != 0) check("beat", {30'd0, rsp_data, rsp_last, rsp_ovf}, {30'd0, sb.pop_front()});
    end
  end

  initial begin
    int lat;
    int idx[3];
    idx = '{47, 48, 63};
    rst = 1'b1; req_valid = 1'b0; req_n = '0; req_stream = 1'b0; abort = 1'b0; rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_outs", {26'd0, rsp_valid, rsp_data, rsp_last, rsp_ovf, busy, req_ready},
          {26'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1});
    @(posedge clk);
    #1 rst = 1'b0;

    // n=0 single
    rsp_ready = 1'b1;
    push_single(0);
    req(0, 1'b0);
    wait_valid(lat);
    check("lat_n0", 64'(lat), 64'd2);
    drain();

    // n=10 single, held off by backpressure
    rsp_ready = 1'b0;
    push_single(10);
    req(10, 1'b0);
    wait_valid(lat);
    check("lat_n10", 64'(lat), 64'd12);
    repeat (3) begin
      @(negedge clk);
      check("done_hold", {62'd0, req_ready, busy}, {62'd0, 1'b0, 1'b1});
    end
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    drain();
    @(negedge clk);
    check("idle_after_n10", {62'd0, req_ready, busy}, {62'd0, 1'b1, 1'b0});
    @(posedge clk);
    #1;

    // overflow boundary
    foreach (idx[i]) begin
      push_single(idx[i]);
      req(idx[i], 1'b0);
      wait_valid(lat);
      check("lat_big", 64'(lat), 64'(idx[i] + 2));
      drain();
    end

    // stream n=5 with rsp_ready pattern 1,0,0,1,...
    push_stream(5);
    req(5, 1'b1);
    wait_valid(lat);
    check("lat_stream", 64'(lat), 64'd1);
    for (int i = 1; i < 60 && sb.size() != 0; i++) begin
      @(posedge clk);
      #1 rsp_ready = (i % 4 == 0) || (i % 4 == 3);
      @(negedge clk);
    end
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    drain();
    @(negedge clk);
    check("idle_after_stream", {63'd0, busy}, 64'd0);
    @(posedge clk);

    // abort in IDLE only masks req_ready
    #1 abort = 1'b1;
    @(negedge clk);
    check("abort_idle", {62'd0, req_ready, busy}, {62'd0, 1'b0, 1'b0});
    @(posedge clk);
    #1 abort = 1'b0;
    @(negedge clk);
    check("abort_idle_release", {63'd0, req_ready}, 64'd1);
    @(posedge clk);
    #1;

    // abort two cycles into RUN
    req(20, 1'b0);
    @(posedge clk);
    #1 abort = 1'b1;
    @(negedge clk);
    check("busy_before_abort", {63'd0, busy}, 64'd1);
    @(posedge clk);
    #1 abort = 1'b0;
    @(negedge clk);
    check("after_abort", {61'd0, busy, req_ready, rsp_valid}, {61'd0, 1'b0, 1'b1, 1'b0});
    repeat (25) @(negedge clk);
    check("no_beat_after_abort", {62'd0, rsp_valid, busy}, 64'd0);
    @(posedge clk);
    #1;
    push_single(3);
    req(3, 1'b0);
    wait_valid(lat);
    check("lat_n3", 64'(lat), 64'd5);
    drain();

    // req_valid held while DONE stalls
    rsp_ready = 1'b0;
    push_single(4);
    push_single(2);
    req(4, 1'b0);
    wait_valid(lat);
    @(posedge clk);
    #1 req_valid = 1'b1; req_n = 6'd2; req_stream = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("no_accept_done", {61'd0, req_ready, rsp_valid, busy}, {61'd0, 3'b011});
    end
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    req(2, 1'b0);
    drain();

    // reset mid-stream
    rsp_ready = 1'b0;
    req(10, 1'b1);
    wait_valid(lat);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("reset_mid", {26'd0, rsp_valid, rsp_data, rsp_last, rsp_ovf, busy, req_ready},
          {26'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1});
    @(posedge clk);
    #1 rst = 1'b0;
    rsp_ready = 1'b1;
    push_stream(1);
    req(1, 1'b1);
    drain();
    repeat (3) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
